// File: rtl/femto_timebase.sv
// femto_timebase: timing companion to the PLL clock generator.
// Derives 1 us / 1 ms ticks from clk, a stretched system reset, and a one-shot
// microsecond delay timer with a start/busy/done handshake.
//
// Parameters:
//   FREQ        clock frequency in integer MHz (1..255)
//   RST_HOLD_US us that rst_out stays high after reset deasserts (0..65535)
//
// Ports:
//   clk       system clock from the PLL (only clock)
//   reset     synchronous, active-high reset
//   rst_out   stretched system reset, active high
//   us_tick   one-cycle pulse every FREQ cycles
//   ms_tick   one-cycle pulse every 1000 us_ticks, coincident with us_tick
//   delay_us  delay length in us, sampled when start is accepted
//   start     delay request, level-sampled
//   busy      delay in progress
//   done      one-cycle completion pulse
module femto_timebase #(
  parameter int unsigned FREQ        = 40,
  parameter int unsigned RST_HOLD_US = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rst_out,
  output logic        us_tick,
  output logic        ms_tick,
  input  logic [15:0] delay_us,
  input  logic        start,
  output logic        busy,
  output logic        done
);

  // Out-of-range FREQ stops elaboration through an instance of a missing module.
  if ((FREQ < 1) || (FREQ > 255)) begin : g_freq_range_error
    femto_timebase_freq_out_of_range u_freq_out_of_range ();
  end

  localparam int unsigned    PW        = (FREQ > 1) ? $clog2(FREQ) : 1;
  localparam logic [PW-1:0]  PC_LAST   = PW'(FREQ - 1);
  localparam logic [15:0]    HOLD_LAST = (RST_HOLD_US == 0) ? 16'd0 : 16'(RST_HOLD_US - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  logic [PW-1:0] pc_q;
  logic          pc_wrap;
  logic          us_tick_q;
  logic [9:0]    ms_cnt_q;
  logic          ms_tick_q;
  logic [15:0]   hold_q;
  logic          rst_out_q;
  state_e        state_q;
  logic [15:0]   cnt_q;
  logic          busy_q;
  logic          done_q;

  assign pc_wrap = (pc_q == PC_LAST);

  // Prescaler: us_tick is registered on the edge where pc wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      us_tick_q <= 1'b0;
    end else begin
      us_tick_q <= pc_wrap;
      pc_q      <= pc_wrap ? '0 : pc_q + 1'b1;
    end
  end

  // ms counter keys off the wrap itself so ms_tick lands with the 1000th us_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_cnt_q  <= '0;
      ms_tick_q <= 1'b0;
    end else begin
      ms_tick_q <= pc_wrap && (ms_cnt_q == 10'd999);
      if (pc_wrap) begin
        ms_cnt_q <= (ms_cnt_q == 10'd999) ? '0 : ms_cnt_q + 10'd1;
      end
    end
  end

  // Reset stretcher counts registered us_ticks; drops on the edge after the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      rst_out_q <= 1'b1;
    end else if (rst_out_q) begin
      if (RST_HOLD_US == 0) begin
        rst_out_q <= 1'b0;
      end else if (us_tick_q) begin
        if (hold_q == HOLD_LAST) begin
          rst_out_q <= 1'b0;
        end else begin
          hold_q <= hold_q + 16'd1;
        end
      end
    end
  end

  // Delay FSM. A zero-length request arriving while done is already high is
  // held off one cycle so every done pulse stays exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !rst_out_q) begin
            if (delay_us == 16'd0) begin
              if (!done_q) begin
                cnt_q  <= delay_us;
                done_q <= 1'b1;
              end
            end else begin
              cnt_q   <= delay_us;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (us_tick_q) begin
            if (cnt_q == 16'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out = rst_out_q;
  assign us_tick = us_tick_q;
  assign ms_tick = ms_tick_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_femto_timebase.sv
module tb_femto_timebase;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] delay_us;

  logic rst_out, us_tick, ms_tick, busy, done;
  logic rst_out0, us_tick0, ms_tick0, busy0, done0;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;
  int n;

  always #5 clk = ~clk;

  femto_timebase #(.FREQ(4), .RST_HOLD_US(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .rst_out  (rst_out),
    .us_tick  (us_tick),
    .ms_tick  (ms_tick),
    .delay_us (delay_us),
    .start    (start),
    .busy     (busy),
    .done     (done)
  );

  femto_timebase #(.FREQ(4), .RST_HOLD_US(0)) dut_h0 (
    .clk      (clk),
    .reset    (reset),
    .rst_out  (rst_out0),
    .us_tick  (us_tick0),
    .ms_tick  (ms_tick0),
    .delay_us (delay_us),
    .start    (start),
    .busy     (busy0),
    .done     (done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, ecnt, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40 && done !== 1'b1) begin
      tick();
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    delay_us = '0;
    repeat (3) tick();

    chk("rst_rst_out", 32'(rst_out), 32'd1);
    chk("rst_us_tick", 32'(us_tick), 32'd0);
    chk("rst_ms_tick", 32'(ms_tick), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_h0",      32'(rst_out0), 32'd1);

    // Scenarios 1 and 2: free-running ticks and reset stretch.
    reset = 1'b0;
    ecnt  = 0;
    for (int e = 1; e <= 4100; e++) begin
      tick();
      chk("us_tick", 32'(us_tick), 32'(ecnt % 4 == 0));
      chk("ms_tick", 32'(ms_tick), 32'(ecnt == 4000));
      chk("rst_out", 32'(rst_out), 32'(ecnt <= 12));
      chk("rst_out_h0", 32'(rst_out0), 32'd0);
    end

    // Scenario 3: delay 5 accepted at edge 4101 with a tick in the acceptance cycle -> 20 cycles.
    start = 1'b1; delay_us = 16'd5;
    tick();
    start = 1'b0;
    chk("s3_busy", 32'(busy), 32'd1);
    chk("s3_done_low", 32'(done), 32'd0);
    wait_done(n);
    chk("s3_lat", 32'(n), 32'd20);
    chk("s3_busy_fall", 32'(busy), 32'd0);

    // Start in the done cycle: delay 2 accepted at 4122, first counted tick 4125 -> 7 cycles.
    start = 1'b1; delay_us = 16'd2;
    tick();
    start = 1'b0;
    chk("s5c_done_width", 32'(done), 32'd0);
    chk("s5c_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("s5c_lat", 32'(n), 32'd7);
    tick();
    chk("s5c_done_drop", 32'(done), 32'd0);
    tick();

    // Delay 5 accepted at 4132 (tick counted next edge) -> 17 cycles; restart mid-delay ignored.
    start = 1'b1; delay_us = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5b_busy", 32'(busy), 32'd1);
    end
    start = 1'b1; delay_us = 16'd1;
    tick();
    tick();
    start = 1'b0; delay_us = 16'd5;
    chk("s5b_busy_mid", 32'(busy), 32'd1);
    wait_done(n);
    chk("s5b_lat", 32'(5 + n), 32'd17);

    // Scenario 4: zero-length delays.
    tick();
    start = 1'b1; delay_us = 16'd0;
    tick();
    chk("s4_done1", 32'(done), 32'd1);
    chk("s4_busy1", 32'(busy), 32'd0);
    tick();
    chk("s4_done2", 32'(done), 32'd0);
    tick();
    chk("s4_done3", 32'(done), 32'd1);
    chk("s4_busy3", 32'(busy), 32'd0);
    tick();
    chk("s4_done4", 32'(done), 32'd0);
    start = 1'b0;
    tick();
    chk("s4_done5", 32'(done), 32'd0);
    chk("s4_busy5", 32'(busy), 32'd0);

    // Scenario 6: reset while running with cnt=3 (accepted 4156, counted ticks at 4157 and 4161).
    start = 1'b1; delay_us = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_busy", 32'(busy), 32'd1);
    end
    reset = 1'b1;
    tick();
    chk("s6_busy_rst", 32'(busy), 32'd0);
    chk("s6_done_rst", 32'(done), 32'd0);
    chk("s6_rst_out", 32'(rst_out), 32'd1);
    chk("s6_us_tick", 32'(us_tick), 32'd0);
    chk("s6_ms_tick", 32'(ms_tick), 32'd0);
    chk("s6_rst_h0", 32'(rst_out0), 32'd1);

    // Release; start held while rst_out is high must be ignored.
    reset = 1'b0;
    ecnt  = 0;
    start = 1'b1; delay_us = 16'd2;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (ecnt == 13) start = 1'b0;
      chk("s6_us_phase", 32'(us_tick), 32'(ecnt % 4 == 0));
      chk("s6_rst_hold", 32'(rst_out), 32'(ecnt <= 12));
      chk("s6_no_busy", 32'(busy), 32'd0);
      chk("s6_no_done", 32'(done), 32'd0);
      chk("s6_rst_h0_rel", 32'(rst_out0), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
